// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder model.
package sram_resp_pkg;

    // Read-side FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Byte lanes of the 16-bit data bus.
    localparam int LANE_W      = 8;
    localparam int LO_LANE_LSB = 0;
    localparam int LO_LANE_MSB = 7;
    localparam int HI_LANE_LSB = 8;
    localparam int HI_LANE_MSB = 15;

endpackage

// File: rtl/sram_resp_array.sv
// Byte-enabled 2^MEM_AW x 16 storage: one synchronous write port, one
// asynchronous read port. Contents have no reset and survive rst.
module sram_resp_array
    import sram_resp_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              wr_lo,
    input  logic              wr_hi,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    // Per-lane write; each enabled lane commits at the sampling edge.
    always_ff @(posedge clock) begin
        if (wr_lo) begin
            mem[wr_addr][LO_LANE_MSB:LO_LANE_LSB] <= wr_data[LO_LANE_MSB:LO_LANE_LSB];
        end
        if (wr_hi) begin
            mem[wr_addr][HI_LANE_MSB:HI_LANE_LSB] <= wr_data[HI_LANE_MSB:HI_LANE_LSB];
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sram_responder.sv
// Clocked model of an external 16-bit asynchronous SRAM with a
// configurable read latency, used to exercise the controller's stall path.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic              dq_drive,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic              protocol_err
);

    // Counter holds 0..READ_LAT-1; at least one bit even for READ_LAT=1.
    localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] lat_addr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] out_word;
    logic [DATA_W-1:0] arr_word;
    logic              load_out;
    logic              rd_req;
    logic              wr;
    logic              conflict;
    logic              addr_match;
    logic              bus_en;

    assign rd_req     = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign wr         = !SRAM_CE_N && !SRAM_WE_N;
    assign conflict   = !SRAM_CE_N && !SRAM_OE_N && !SRAM_WE_N;
    assign addr_match = (SRAM_ADDR == lat_addr);

    sram_resp_array #(
        .MEM_AW (MEM_AW),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .wr_lo   (wr && !SRAM_LB_N),
        .wr_hi   (wr && !SRAM_UB_N),
        .wr_addr (SRAM_ADDR[MEM_AW-1:0]),
        .wr_data (SRAM_DQ),
        .rd_addr (lat_addr[MEM_AW-1:0]),
        .rd_data (arr_word)
    );

    // Next-state logic: writes preempt any read; address changes restart the wait.
    always_comb begin
        state_nxt    = state;
        lat_addr_nxt = lat_addr;
        cnt_nxt      = cnt;
        load_out     = 1'b0;
        if (wr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state_nxt    = WAIT;
                        lat_addr_nxt = SRAM_ADDR;
                        cnt_nxt      = CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (!rd_req) begin
                        state_nxt = IDLE;
                    end else if (!addr_match) begin
                        // Relatch beats the terminal count: never drive a stale word.
                        lat_addr_nxt = SRAM_ADDR;
                        cnt_nxt      = CNT_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = DRIVE;
                        load_out  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (!rd_req) begin
                        state_nxt = IDLE;
                    end else if (!addr_match) begin
                        state_nxt    = WAIT;
                        lat_addr_nxt = SRAM_ADDR;
                        cnt_nxt      = CNT_LOAD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state and status outputs, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_out) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (conflict) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Address latch, latency counter and output word; only meaningful once loaded.
    always_ff @(posedge clock) begin
        lat_addr <= lat_addr_nxt;
        cnt      <= cnt_nxt;
        if (load_out) begin
            out_word <= arr_word;
        end
    end

    // Combinational enable so the bus is released in the same cycle the request drops.
    assign bus_en   = (state == DRIVE) && rd_req && addr_match;
    assign dq_drive = bus_en && (!SRAM_LB_N || !SRAM_UB_N);

    assign SRAM_DQ[LO_LANE_MSB:LO_LANE_LSB] = (bus_en && !SRAM_LB_N)
        ? out_word[LO_LANE_MSB:LO_LANE_LSB] : {LANE_W{1'bz}};
    assign SRAM_DQ[HI_LANE_MSB:HI_LANE_LSB] = (bus_en && !SRAM_UB_N)
        ? out_word[HI_LANE_MSB:HI_LANE_LSB] : {LANE_W{1'bz}};

endmodule
